alu_seq: RTL and testbench

Parametrised, multi-cycle execute-stage ALU for the miniRV core. It replaces the single-cycle ALU with a registered-result datapath of configurable width. It adds RV-M style iterative multiply/divide/remainder behind a start/done handshake. All base ops (add/sub/logic/shift/branch compare) keep their `defines.vh` semantics and complete in one cycle.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq request/result bundle.
// The master drives the request and operands.
// The slave (the ALU) drives the handshake status and the registered result.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [4:0]       alu_op;
   logic [2:0]       sel;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] rd2;
   logic [WIDTH-1:0] sext;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] C;
   logic             f;

   modport master (
      output start, alu_op, sel, A, rd2, sext,
      input  ready, busy, done, C, f
   );

   modport slave (
      input  start, alu_op, sel, A, rd2, sext,
      output ready, busy, done, C, f
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute-stage ALU for miniRV with a registered result.
// Base ops complete in one cycle. Multiply, divide and remainder run as
// WIDTH-step iterative ops behind the start/done handshake.
// Build option: define ALU_MULDIV_EN to compile in the mul/div datapath and the
// CALC state. Without it, codes 5'h10..5'h16 take the default A+B path.
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int unsigned SHW = $clog2(WIDTH);

   // Base op codes and selector/flag values, mirroring defines.vh
   localparam logic [4:0] ALU_ADD = 5'h00;
   localparam logic [4:0] ALU_SUB = 5'h01;
   localparam logic [4:0] ALU_AND = 5'h02;
   localparam logic [4:0] ALU_OR  = 5'h03;
   localparam logic [4:0] ALU_XOR = 5'h04;
   localparam logic [4:0] ALU_SLL = 5'h05;
   localparam logic [4:0] ALU_SRL = 5'h06;
   localparam logic [4:0] ALU_SRA = 5'h07;
   localparam logic [4:0] ALU_BEQ = 5'h08;
   localparam logic [4:0] ALU_BNE = 5'h09;
   localparam logic [4:0] ALU_BLT = 5'h0A;
   localparam logic [4:0] ALU_BGE = 5'h0B;
   localparam logic [2:0] ALU_RS2 = 3'd0;
   localparam logic [2:0] ALU_EXT = 3'd1;
   localparam logic       COM_YES = 1'b1;
   localparam logic       COM_NO  = 1'b0;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_c;
   logic [WIDTH-1:0] w_c_nxt;
   logic             r_f;
   logic             w_f_nxt;
   logic             r_done;
   logic             r_ready;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_base_c;
   logic             w_base_f;

`ifdef ALU_MULDIV_EN
   localparam int unsigned CW = SHW + 1;
   localparam int unsigned W2 = 2 * WIDTH;

   localparam logic [4:0] ALU_MUL   = 5'h10;
   localparam logic [4:0] ALU_MULH  = 5'h11;
   localparam logic [4:0] ALU_MULHU = 5'h12;
   localparam logic [4:0] ALU_DIV   = 5'h13;
   localparam logic [4:0] ALU_DIVU  = 5'h14;
   localparam logic [4:0] ALU_REM   = 5'h15;
   localparam logic [4:0] ALU_REMU  = 5'h16;

   logic             r_busy;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [4:0]       r_md_op;
   logic [4:0]       w_md_op_nxt;
   logic             r_is_mul;
   logic             w_is_mul_nxt;
   logic             r_neg_q;
   logic             w_neg_q_nxt;
   logic             r_neg_r;
   logic             w_neg_r_nxt;
   logic [W2-1:0]    r_acc;
   logic [W2-1:0]    w_acc_nxt;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] w_dvs_nxt;

   logic             w_is_md;
   logic             w_is_mul;
   logic             w_op_signed;
   logic             w_sa;
   logic             w_sb;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH:0]   w_madd;
   logic [WIDTH:0]   w_dsh;
   logic [WIDTH:0]   w_ddiff;
   logic [W2-1:0]    w_step;
   logic [W2-1:0]    w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_md_res;
`endif

   // B operand source
   always_comb begin
      case (bus.sel)
         ALU_RS2: w_b = bus.rd2;
         ALU_EXT: w_b = bus.sext;
         default: w_b = bus.rd2;
      endcase
   end

   // Single-cycle base ops; branch compares return A+B in C
   always_comb begin
      w_base_c = bus.A + w_b;
      w_base_f = COM_NO;
      case (bus.alu_op)
         ALU_ADD: w_base_c = bus.A + w_b;
         ALU_SUB: w_base_c = bus.A - w_b;
         ALU_AND: w_base_c = bus.A & w_b;
         ALU_OR:  w_base_c = bus.A | w_b;
         ALU_XOR: w_base_c = bus.A ^ w_b;
         ALU_SLL: w_base_c = bus.A << w_b[SHW-1:0];
         ALU_SRL: w_base_c = bus.A >> w_b[SHW-1:0];
         ALU_SRA: w_base_c = $signed(bus.A) >>> w_b[SHW-1:0];
         ALU_BEQ: w_base_f = (bus.A == w_b) ? COM_YES : COM_NO;
         ALU_BNE: w_base_f = (bus.A != w_b) ? COM_YES : COM_NO;
         ALU_BLT: w_base_f = ($signed(bus.A) <  $signed(w_b)) ? COM_YES : COM_NO;
         ALU_BGE: w_base_f = ($signed(bus.A) >= $signed(w_b)) ? COM_YES : COM_NO;
         default: ;
      endcase
   end

`ifdef ALU_MULDIV_EN
   // Request decode and operand magnitudes for the iterative ops
   always_comb begin
      w_is_md     = bus.alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV,
                                       ALU_DIVU, ALU_REM, ALU_REMU};
      w_is_mul    = bus.alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHU};
      w_op_signed = bus.alu_op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
      w_sa        = w_op_signed & bus.A[WIDTH-1];
      w_sb        = w_op_signed & w_b[WIDTH-1];
      w_abs_a     = w_sa ? -bus.A : bus.A;
      w_abs_b     = w_sb ? -w_b : w_b;
   end

   // One shift-add (multiply) or restoring-subtract (divide) step.
   // r_acc holds {upper, lower}: product/multiplier or remainder/quotient.
   always_comb begin
      w_madd  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
      w_dsh   = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
      w_ddiff = w_dsh - {1'b0, r_dvs};
      if (r_is_mul) begin
         w_step = {w_madd, r_acc[WIDTH-1:1]};
      end else if (!w_ddiff[WIDTH]) begin
         w_step = {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_step = {w_dsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction and result select on the final step
   always_comb begin
      w_prod = r_neg_q ? -w_step : w_step;
      w_quot = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
      w_rem  = r_neg_r ? -w_step[W2-1:WIDTH] : w_step[W2-1:WIDTH];
      case (r_md_op)
         ALU_MUL:             w_md_res = w_prod[WIDTH-1:0];
         ALU_MULH, ALU_MULHU: w_md_res = w_prod[W2-1:WIDTH];
         ALU_DIV, ALU_DIVU:   w_md_res = w_quot;
         ALU_REM, ALU_REMU:   w_md_res = w_rem;
         default:             w_md_res = w_rem;
      endcase
   end
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, result capture and iteration control
   always_comb begin
      w_state_nxt  = IDLE;
      w_c_nxt      = r_c;
      w_f_nxt      = r_f;
`ifdef ALU_MULDIV_EN
      w_cnt_nxt    = r_cnt;
      w_acc_nxt    = r_acc;
      w_dvs_nxt    = r_dvs;
      w_md_op_nxt  = r_md_op;
      w_is_mul_nxt = r_is_mul;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
`endif
      case (r_state)
`ifdef ALU_MULDIV_EN
         CALC: begin
            w_state_nxt = CALC;
            w_cnt_nxt   = r_cnt - CW'(1);
            w_acc_nxt   = w_step;
            if (r_cnt == CW'(1)) begin
               w_state_nxt = DONE;
               w_c_nxt     = w_md_res;
               w_f_nxt     = COM_NO;
            end
         end
`endif
         // IDLE and DONE both accept a new request
         default: begin
            if (bus.start) begin
`ifdef ALU_MULDIV_EN
               if (w_is_md) begin
                  w_state_nxt  = CALC;
                  w_cnt_nxt    = CW'(WIDTH);
                  w_acc_nxt    = {{WIDTH{1'b0}}, w_abs_a};
                  w_dvs_nxt    = w_abs_b;
                  w_md_op_nxt  = bus.alu_op;
                  w_is_mul_nxt = w_is_mul;
                  // Divide by zero keeps the all-ones quotient unsigned
                  w_neg_q_nxt  = (w_sa ^ w_sb) & (w_is_mul | (w_b != '0));
                  w_neg_r_nxt  = w_sa;
               end else
`endif
               begin
                  w_state_nxt = DONE;
                  w_c_nxt     = w_base_c;
                  w_f_nxt     = w_base_f;
               end
            end
         end
      endcase
   end

   // Registered result and handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_c     <= '0;
         r_f     <= COM_NO;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_c     <= w_c_nxt;
         r_f     <= w_f_nxt;
         r_done  <= (w_state_nxt == DONE);
         r_ready <= (w_state_nxt != CALC);
      end
   end

`ifdef ALU_MULDIV_EN
   // Iteration registers and busy flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_dvs    <= '0;
         r_md_op  <= '0;
         r_is_mul <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         r_busy   <= (w_state_nxt == CALC);
         r_cnt    <= w_cnt_nxt;
         r_acc    <= w_acc_nxt;
         r_dvs    <= w_dvs_nxt;
         r_md_op  <= w_md_op_nxt;
         r_is_mul <= w_is_mul_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
      end
   end

   assign bus.busy = r_busy;
`else
   assign bus.busy = 1'b0;
`endif

   assign bus.C     = r_c;
   assign bus.f     = r_f;
   assign bus.done  = r_done;
   assign bus.ready = r_ready;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=32) against a
// behavioural model. Mul/div checks are built when ALU_MULDIV_EN is defined;
// otherwise the bench checks that those codes take the A+B default path.
module tb_alu_seq;
   localparam int unsigned W = 32;

   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_SUB   = 5'h01;
   localparam logic [4:0] OP_AND   = 5'h02;
   localparam logic [4:0] OP_OR    = 5'h03;
   localparam logic [4:0] OP_XOR   = 5'h04;
   localparam logic [4:0] OP_SLL   = 5'h05;
   localparam logic [4:0] OP_SRL   = 5'h06;
   localparam logic [4:0] OP_SRA   = 5'h07;
   localparam logic [4:0] OP_BEQ   = 5'h08;
   localparam logic [4:0] OP_BNE   = 5'h09;
   localparam logic [4:0] OP_BLT   = 5'h0A;
   localparam logic [4:0] OP_BGE   = 5'h0B;
   localparam logic [4:0] OP_MUL   = 5'h10;
   localparam logic [4:0] OP_MULH  = 5'h11;
   localparam logic [4:0] OP_MULHU = 5'h12;
   localparam logic [4:0] OP_DIV   = 5'h13;
   localparam logic [4:0] OP_DIVU  = 5'h14;
   localparam logic [4:0] OP_REM   = 5'h15;
   localparam logic [4:0] OP_REMU  = 5'h16;
   localparam logic [2:0] SEL_RS2  = 3'd0;
   localparam logic [2:0] SEL_EXT  = 3'd1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_overlap = 0;
   int   n_busy_seen = 0;
   logic [4:0] md_codes [7] = '{OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Track busy/done overlap and whether busy ever rose
   always @(negedge clk) begin
      if (bus.busy && bus.done) n_overlap++;
      if (bus.busy) n_busy_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural model: what the ALU should return for one request
   function automatic void model(input logic [4:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] rd2,
                                 input logic [31:0] sext,
                                 output logic [31:0] c, output logic fl);
      logic [31:0]     b;
      int              sa;
      int              sb;
      longint          p;
      longint unsigned pu;
      b  = (sel == SEL_EXT) ? sext : rd2;
      sa = a;
      sb = b;
      c  = a + b;
      fl = 1'b0;
      p  = longint'(sa) * longint'(sb);
      pu = {32'd0, a} * {32'd0, b};
      case (op)
         OP_SUB: c = a - b;
         OP_AND: c = a & b;
         OP_OR:  c = a | b;
         OP_XOR: c = a ^ b;
         OP_SLL: c = a << b[4:0];
         OP_SRL: c = a >> b[4:0];
         OP_SRA: c = 32'(sa >>> b[4:0]);
         OP_BEQ: fl = (a == b);
         OP_BNE: fl = (a != b);
         OP_BLT: fl = (sa < sb);
         OP_BGE: fl = (sa >= sb);
`ifdef ALU_MULDIV_EN
         OP_MUL:   c = p[31:0];
         OP_MULH:  c = p[63:32];
         OP_MULHU: c = pu[63:32];
         OP_DIV: begin
            if (b == 0) c = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) c = 32'h8000_0000;
            else c = 32'(sa / sb);
         end
         OP_REM: begin
            if (b == 0) c = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) c = 32'd0;
            else c = 32'(sa % sb);
         end
         OP_DIVU: c = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: c = (b == 0) ? a : a % b;
`endif
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 40));
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input logic [4:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] rd2, input logic [31:0] sext);
      bus.start  = 1'b1;
      bus.alu_op = op;
      bus.sel    = sel;
      bus.A      = a;
      bus.rd2    = rd2;
      bus.sext   = sext;
   endtask

   // Issue one single-cycle op at a negedge; check the result one cycle later
   task automatic base_op(input string tag, input logic [4:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] sext);
      logic [31:0] ec;
      logic        ef;
      model(op, sel, a, rd2, sext, ec, ef);
      drive(op, sel, a, rd2, sext);
      @(negedge clk);
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_C"}, bus.C, ec);
      check({tag, "_f"}, 32'(bus.f), 32'(ef));
   endtask

   // Issue an iterative op; check busy, latency and result
   task automatic md_op(input string tag, input logic [4:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] sext);
      logic [31:0] ec;
      logic        ef;
      int          k;
      model(op, sel, a, rd2, sext, ec, ef);
      drive(op, sel, a, rd2, sext);
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.rd2   = $urandom;
      bus.sext  = $urandom;
      k = 1;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_rdy"}, 32'(bus.ready), 32'd0);
      while (!bus.done && k < 64) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_lat"}, 32'(k), 32'd33);
      check({tag, "_C"}, bus.C, ec);
      check({tag, "_f"}, 32'(bus.f), 32'(ef));
   endtask

   initial begin
      logic [4:0] op;
      int         k;
      int         nd;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.alu_op = OP_ADD;
      bus.sel    = SEL_RS2;
      bus.A      = '0;
      bus.rd2    = '0;
      bus.sext   = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_C", bus.C, 32'd0);
      check("rst_f", 32'(bus.f), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed base ops, including back-to-back issue from DONE
      base_op("add_ext", OP_ADD, SEL_EXT, 32'd5, 32'd100, 32'd7);
      check("add_ext_C12", bus.C, 32'd12);
      base_op("add_b2b", OP_ADD, SEL_RS2, 32'd1, 32'd2, 32'd50);
      base_op("blt", OP_BLT, SEL_RS2, 32'hFFFF_FFFF, 32'd1, 32'd0);
      check("blt_f_yes", 32'(bus.f), 32'd1);
      check("blt_C0", bus.C, 32'd0);
      base_op("bge", OP_BGE, SEL_RS2, 32'hFFFF_FFFF, 32'd1, 32'd0);
      base_op("sra36", OP_SRA, SEL_EXT, 32'h8000_0000, 32'd0, 32'd36);
      check("sra36_val", bus.C, 32'hF800_0000);
      bus.start = 1'b0;
      @(negedge clk);
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_ready", 32'(bus.ready), 32'd1);

      // Randomized back-to-back base ops, one per cycle
      for (int i = 0; i < 300; i++) begin
         op = 5'($urandom_range(0, 31));
`ifdef ALU_MULDIV_EN
         if (op >= OP_MUL && op <= OP_REMU) op = op - OP_MUL;
`endif
         base_op("rnd_base", op, 3'($urandom_range(0, 7)), rnd32(), rnd32(), rnd32());
      end
      bus.start = 1'b0;
      @(negedge clk);

`ifdef ALU_MULDIV_EN
      md_op("mul", OP_MUL, SEL_RS2, 32'hFFFF_FFFE, 32'd3, 32'd0);
      check("mul_val", bus.C, 32'hFFFF_FFFA);
      md_op("mulh", OP_MULH, SEL_RS2, 32'hFFFF_FFFE, 32'd3, 32'd0);
      check("mulh_val", bus.C, 32'hFFFF_FFFF);
      md_op("mulhu", OP_MULHU, SEL_EXT, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
      check("mulhu_val", bus.C, 32'hFFFF_FFFE);
      md_op("div_ovf", OP_DIV, SEL_RS2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      check("div_ovf_val", bus.C, 32'h8000_0000);
      md_op("rem_ovf", OP_REM, SEL_RS2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      check("rem_ovf_val", bus.C, 32'd0);
      md_op("divu_z", OP_DIVU, SEL_RS2, 32'd13, 32'd0, 32'd5);
      check("divu_z_val", bus.C, 32'hFFFF_FFFF);
      md_op("remu_z", OP_REMU, SEL_RS2, 32'd13, 32'd0, 32'd5);
      check("remu_z_val", bus.C, 32'd13);
      md_op("rem_neg", OP_REM, SEL_RS2, 32'hFFFF_FFF9, 32'd2, 32'd0);
      check("rem_neg_val", bus.C, 32'hFFFF_FFFF);
      md_op("div_z_neg", OP_DIV, SEL_RS2, 32'hFFFF_FFFB, 32'd0, 32'd0);
      md_op("rem_z_neg", OP_REM, SEL_RS2, 32'hFFFF_FFFB, 32'd0, 32'd0);
      md_op("div_neg", OP_DIV, SEL_RS2, 32'hFFFF_FFF9, 32'd2, 32'd0);

      for (int i = 0; i < 40; i++) begin
         md_op("rnd_md", md_codes[$urandom_range(0, 6)], 3'($urandom_range(0, 2)),
               rnd32(), rnd32(), rnd32());
      end

      // start pulsed during CALC must be ignored
      drive(OP_DIV, SEL_RS2, 32'd100, 32'd7, 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      k = 1;
      while (k < 5) begin
         @(negedge clk);
         k++;
      end
      drive(OP_ADD, SEL_RS2, 32'd1, 32'd1, 32'd0);
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      while (!bus.done && k < 64) begin
         @(negedge clk);
         k++;
      end
      check("ign_lat", 32'(k), 32'd33);
      check("ign_C", bus.C, 32'd14);
      @(negedge clk);
      check("ign_done_pulse", 32'(bus.done), 32'd0);

      // Reset mid-CALC aborts the operation
      drive(OP_DIV, SEL_RS2, 32'd1000, 32'd3, 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      k = 1;
      while (k < 10) begin
         @(negedge clk);
         k++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_C", bus.C, 32'd0);
      check("abort_ready", 32'(bus.ready), 32'd1);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      check("abort_no_done", 32'(nd), 32'd0);
      base_op("post_abort", OP_SUB, SEL_RS2, 32'd10, 32'd3, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      check("busy_seen", 32'(n_busy_seen != 0), 32'd1);
`else
      base_op("mul_off", OP_MUL, SEL_RS2, 32'd2, 32'd3, 32'd0);
      check("mul_off_C5", bus.C, 32'd5);
      for (int i = 0; i < 7; i++) begin
         base_op("md_off", md_codes[i], SEL_EXT, rnd32(), rnd32(), rnd32());
      end
      bus.start = 1'b0;
      @(negedge clk);
      check("busy_never", 32'(n_busy_seen), 32'd0);
`endif
      check("busy_done_overlap", 32'(n_overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
